// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage: load/store size codes and FSM states.
package ma_defs;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIN  = 2'd2
    } ma_state_e;

    function automatic logic is_byte(input logic [2:0] code);
        return (code == LDST_B) || (code == LDST_BU);
    endfunction

    // Anything that is neither byte nor half is handled as a word access.
    function automatic logic is_half(input logic [2:0] code);
        return (code == LDST_H) || (code == LDST_HU);
    endfunction

endpackage

// File: rtl/ma_ld_align.sv
// Load data formatter: picks the addressed byte/half lane and sign- or zero-extends it.
module ma_ld_align
    import ma_defs::*;
(
    input  logic [1:0]  adr_i,
    input  logic [2:0]  code_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{adr_i, 3'b000} +: 8];
        half_v = adr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (code_i)
            LDST_B:  data_o = {{24{byte_v[7]}}, byte_v};
            LDST_BU: data_o = {24'd0, byte_v};
            LDST_H:  data_o = {{16{half_v[15]}}, half_v};
            LDST_HU: data_o = {16'd0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: issues one D-side request per ld/st, stalls the pipe while waiting, registers WB data.
//   state | meaning
//   IDLE  | no access outstanding; request issued combinationally, zero-wait ack completes here
//   WAIT  | request held stable until ack or timeout; pipeline stalled
//   FIN   | final stall cycle; WB regs load from the hold register
module ma_stage
    import ma_defs::*;
#(
    parameter int unsigned TMO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic        stall,
    input  logic        rst_pipe,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dc_stall,
    output logic        dc_stall_fin,
    output logic        ma_misalign,
    output logic        ma_bus_err,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] wbk_data_wb,
    output logic        wbk_rd_reg_wb
);

    localparam logic [TMO_W-1:0] TMO_MAX = '1;
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    ma_state_e         state_q, state_d;
    logic [TMO_W-1:0]  count_q, count_d;
    logic [31:0]       hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        is_mem, misalign, access, mis_pulse;
    logic        req, zero_wait, timeout;
    logic [3:0]  be;
    logic [31:0] wdata, ld_fmt;

    assign is_mem   = cmd_ld_ma | cmd_st_ma;
    assign misalign = is_mem & (is_half(ldst_code_ma) ? rd_data_ma[0] :
                                is_byte(ldst_code_ma) ? 1'b0 : (rd_data_ma[1:0] != 2'b00));
    assign access   = is_mem & ~misalign & ~rst_pipe;

    // done_q blocks a second pulse/issue while another stall source holds the same instruction.
    assign mis_pulse = is_mem & misalign & ~rst_pipe & ~done_q & (state_q == IDLE);

    always_comb begin
        if (is_byte(ldst_code_ma)) begin
            be    = 4'b0001 << rd_data_ma[1:0];
            wdata = {4{st_data_ma[7:0]}};
        end else if (is_half(ldst_code_ma)) begin
            be    = rd_data_ma[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data_ma[15:0]}};
        end else begin
            be    = 4'b1111;
            wdata = st_data_ma;
        end
    end

    ma_ld_align u_ld_align (
        .adr_i   (rd_data_ma[1:0]),
        .code_i  (ldst_code_ma),
        .rdata_i (dmem_rdata),
        .data_o  (ld_fmt)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hold_d       = hold_q;
        done_d       = done_q;
        err_d        = err_q;
        req          = 1'b0;
        dc_stall     = 1'b0;
        dc_stall_fin = 1'b0;
        timeout      = 1'b0;
        zero_wait    = 1'b0;
        case (state_q)
            IDLE: begin
                req = access & ~done_q;
                if (req && dmem_ack) begin
                    zero_wait = 1'b1;
                    hold_d    = ld_fmt;
                end else if (req) begin
                    dc_stall = 1'b1;
                    state_d  = WAIT;
                    count_d  = TMO_ONE;
                end
            end
            WAIT: begin
                req      = 1'b1;
                dc_stall = 1'b1;
                if (dmem_ack) begin
                    hold_d  = ld_fmt;
                    state_d = FIN;
                    count_d = '0;
                end else if (count_q == TMO_MAX) begin
                    timeout = 1'b1;
                    hold_d  = '0;
                    state_d = FIN;
                    count_d = '0;
                end else begin
                    count_d = count_q + TMO_ONE;
                end
            end
            FIN: begin
                dc_stall     = 1'b1;
                dc_stall_fin = 1'b1;
                state_d      = IDLE;
                count_d      = '0;
            end
            default: state_d = IDLE;
        endcase
        if (!stall) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end else if (dc_stall_fin || zero_wait || mis_pulse) begin
            done_d = 1'b1;
        end
        if (timeout) err_d = 1'b1;
        if (rst_pipe) begin
            state_d = IDLE;
            count_d = '0;
            hold_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            req     = 1'b0;
            timeout = 1'b0;
        end
    end

    assign dmem_req    = req;
    assign dmem_we     = req & cmd_st_ma;
    assign dmem_adr    = req ? rd_data_ma[31:2] : 30'd0;
    assign dmem_be     = req ? be : 4'd0;
    assign dmem_wdata  = (req & cmd_st_ma) ? wdata : 32'd0;
    assign ma_misalign = mis_pulse;
    assign ma_bus_err  = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_adr_wb     <= '0;
            wbk_data_wb   <= '0;
            wbk_rd_reg_wb <= 1'b0;
        end else if (rst_pipe) begin
            rd_adr_wb     <= '0;
            wbk_data_wb   <= '0;
            wbk_rd_reg_wb <= 1'b0;
        end else if (!stall || dc_stall_fin) begin
            rd_adr_wb     <= rd_adr_ma;
            wbk_data_wb   <= cmd_ld_ma ? (zero_wait ? ld_fmt : hold_q) : rd_data_ma;
            wbk_rd_reg_wb <= wbk_rd_reg_ma & ~misalign & ~err_q & ~cmd_st_ma;
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// Directed self-checking bench for ma_stage; the bench plays the data memory and the global stall.
module tb_ma_stage;

    localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010, C_BU = 3'b100, C_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ld_ma, cmd_st_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        wbk_rd_reg_ma, stall, ext_stall, rst_pipe;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dc_stall, dc_stall_fin, ma_misalign, ma_bus_err;
    logic [4:0]  rd_adr_wb;
    logic [31:0] wbk_data_wb;
    logic        wbk_rd_reg_wb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // global stall is the OR of our own dc_stall and other pipeline stall sources
    assign stall = dc_stall | ext_stall;

    ma_stage #(.TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .rd_adr_ma(rd_adr_ma),
        .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma), .ldst_code_ma(ldst_code_ma),
        .wbk_rd_reg_ma(wbk_rd_reg_ma), .stall(stall), .rst_pipe(rst_pipe),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dc_stall(dc_stall), .dc_stall_fin(dc_stall_fin), .ma_misalign(ma_misalign),
        .ma_bus_err(ma_bus_err), .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb),
        .wbk_rd_reg_wb(wbk_rd_reg_wb)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [31:0] adr,
                          input logic [31:0] sd, input logic [2:0] code,
                          input logic wbk, input logic [4:0] rd);
        cmd_ld_ma     = ld;
        cmd_st_ma     = st;
        rd_data_ma    = adr;
        st_data_ma    = sd;
        ldst_code_ma  = code;
        wbk_rd_reg_ma = wbk;
        rd_adr_ma     = rd;
    endtask

    task automatic clr_op;
        set_op(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr_op(); ext_stall = 1'b0; rst_pipe = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({dmem_req, dmem_we, dc_stall, dc_stall_fin, ma_misalign, ma_bus_err, wbk_rd_reg_wb} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {dmem_req, dmem_we, dc_stall, dc_stall_fin, ma_misalign, ma_bus_err, wbk_rd_reg_wb});
        end
        tests++;
        if (dmem_adr !== 30'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_bus: adr=%h be=%b wdata=%h want all 0", dmem_adr, dmem_be, dmem_wdata);
        end
        tests++;
        if (rd_adr_wb !== 5'd0 || wbk_data_wb !== 32'd0) begin
            fails++;
            $display("FAIL reset_wb: rd_adr=%h data=%h want 0", rd_adr_wb, wbk_data_wb);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_lw_zero_wait;
        set_op(1'b1, 1'b0, 32'h100, 32'd0, C_W, 1'b1, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        tests++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_adr !== 30'h40 || dmem_be !== 4'hF) begin
            fails++;
            $display("FAIL lw_req: req=%b we=%b adr=%h be=%b want 1 0 040 1111", dmem_req, dmem_we, dmem_adr, dmem_be);
        end
        tests++;
        if (dc_stall !== 1'b0) begin
            fails++;
            $display("FAIL lw_nostall: dc_stall=%b want 0", dc_stall);
        end
        next_cycle();
        clr_op(); dmem_ack = 1'b0;
        tests++;
        if (wbk_data_wb !== 32'hDEADBEEF || wbk_rd_reg_wb !== 1'b1 || rd_adr_wb !== 5'd5) begin
            fails++;
            $display("FAIL lw_wb: data=%h en=%b rd=%0d want deadbeef 1 5", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb);
        end
    endtask

    task automatic test_lb_wait;
        int stalls = 0;
        int reqs = 0;
        int fin_bad = 0;
        set_op(1'b1, 1'b0, 32'h103, 32'd0, C_B, 1'b1, 5'd7);
        dmem_rdata = 32'h80FFFFFF;
        for (int c = 0; c < 20; c++) begin
            dmem_ack = (c == 2);
            #1;
            if (!dc_stall) break;
            stalls++;
            if (dmem_req) reqs++;
            if (dc_stall_fin !== (c == 3)) fin_bad++;
            next_cycle();
        end
        tests++;
        if (stalls != 4 || reqs != 3) begin
            fails++;
            $display("FAIL lb_stall: stall_cycles=%0d req_cycles=%0d want 4 3", stalls, reqs);
        end
        tests++;
        if (fin_bad != 0) begin
            fails++;
            $display("FAIL lb_fin: misplaced dc_stall_fin cycles=%0d want 0", fin_bad);
        end
        tests++;
        if (wbk_data_wb !== 32'hFFFFFF80 || wbk_rd_reg_wb !== 1'b1 || rd_adr_wb !== 5'd7) begin
            fails++;
            $display("FAIL lb_wb: data=%h en=%b rd=%0d want ffffff80 1 7", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb);
        end
        tests++;
        if (dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL lb_reissue: req=%b want 0", dmem_req);
        end
        next_cycle();
        clr_op();
    endtask

    task automatic test_back_to_back;
        logic [31:0] adr [6];
        logic [2:0]  code [6];
        logic [31:0] rdat [6];
        logic [31:0] exp [6];
        adr  = '{32'h102, 32'h102, 32'h101, 32'h102, 32'h100, 32'h104};
        code = '{C_HU, C_H, C_BU, C_B, C_H, 3'b011};
        rdat = '{32'h80015A5A, 32'h80015A5A, 32'h00009A00, 32'h00123456, 32'h1234F00F, 32'hCAFEF00D};
        exp  = '{32'h00008001, 32'hFFFF8001, 32'h0000009A, 32'h00000012, 32'hFFFFF00F, 32'hCAFEF00D};
        dmem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op(1'b1, 1'b0, adr[i], 32'd0, code[i], 1'b1, 5'(i + 10));
            dmem_rdata = rdat[i];
            next_cycle();
            tests++;
            if (wbk_data_wb !== exp[i] || rd_adr_wb !== 5'(i + 10)) begin
                fails++;
                $display("FAIL ld_fmt[%0d]: data=%h rd=%0d want %h %0d", i, wbk_data_wb, rd_adr_wb, exp[i], i + 10);
            end
        end
        clr_op(); dmem_ack = 1'b0;
    endtask

    task automatic test_store;
        logic [31:0] adr [4];
        logic [2:0]  code [4];
        logic [31:0] sd [4];
        logic [3:0]  ebe [4];
        logic [31:0] ewd [4];
        adr  = '{32'h102, 32'h101, 32'h104, 32'h103};
        code = '{C_H, C_B, C_W, C_B};
        sd   = '{32'h1234ABCD, 32'h000000EF, 32'h01234567, 32'h00000055};
        ebe  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        ewd  = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h01234567, 32'h55555555};
        dmem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(1'b0, 1'b1, adr[i], sd[i], code[i], 1'b0, 5'd0);
            #1;
            tests++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== ebe[i] || dmem_wdata !== ewd[i]
                || dmem_adr !== adr[i][31:2]) begin
                fails++;
                $display("FAIL st[%0d]: req=%b we=%b be=%b wdata=%h adr=%h want 1 1 %b %h %h",
                         i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_adr, ebe[i], ewd[i], adr[i][31:2]);
            end
            next_cycle();
        end
        tests++;
        if (wbk_rd_reg_wb !== 1'b0) begin
            fails++;
            $display("FAIL st_wb: en=%b want 0", wbk_rd_reg_wb);
        end
        clr_op(); dmem_ack = 1'b0;
    endtask

    task automatic test_misalign;
        dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        set_op(1'b1, 1'b0, 32'h100, 32'd0, C_W, 1'b1, 5'd1);
        next_cycle();
        // misaligned LW held two cycles by an external stall; memory would ack if asked
        set_op(1'b1, 1'b0, 32'h101, 32'd0, C_W, 1'b1, 5'd9);
        ext_stall = 1'b1;
        #1;
        tests++;
        if (dmem_req !== 1'b0 || ma_misalign !== 1'b1 || dc_stall !== 1'b0) begin
            fails++;
            $display("FAIL mis_first: req=%b mis=%b dc_stall=%b want 0 1 0", dmem_req, ma_misalign, dc_stall);
        end
        next_cycle();
        ext_stall = 1'b0;
        #1;
        tests++;
        if (dmem_req !== 1'b0 || ma_misalign !== 1'b0) begin
            fails++;
            $display("FAIL mis_once: req=%b mis=%b want 0 0", dmem_req, ma_misalign);
        end
        next_cycle();
        tests++;
        if (wbk_rd_reg_wb !== 1'b0 || rd_adr_wb !== 5'd9) begin
            fails++;
            $display("FAIL mis_wb: en=%b rd=%0d want 0 9", wbk_rd_reg_wb, rd_adr_wb);
        end
        set_op(1'b1, 1'b0, 32'h103, 32'd0, C_H, 1'b1, 5'd2);
        #1;
        tests++;
        if (dmem_req !== 1'b0 || ma_misalign !== 1'b1) begin
            fails++;
            $display("FAIL mis_lh: req=%b mis=%b want 0 1", dmem_req, ma_misalign);
        end
        next_cycle();
        set_op(1'b0, 1'b1, 32'h101, 32'h5555AAAA, C_H, 1'b0, 5'd0);
        #1;
        tests++;
        if (dmem_req !== 1'b0 || ma_misalign !== 1'b1) begin
            fails++;
            $display("FAIL mis_sh: req=%b mis=%b want 0 1", dmem_req, ma_misalign);
        end
        next_cycle();
        clr_op(); dmem_ack = 1'b0;
    endtask

    task automatic test_stall_once;
        set_op(1'b1, 1'b0, 32'h180, 32'd0, C_W, 1'b1, 5'd12);
        ext_stall = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
        #1;
        tests++;
        if (dmem_req !== 1'b1 || dc_stall !== 1'b0) begin
            fails++;
            $display("FAIL once_req: req=%b dc_stall=%b want 1 0", dmem_req, dc_stall);
        end
        next_cycle();
        ext_stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'hFFFFFFFF;
        #1;
        tests++;
        if (dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL once_reissue: req=%b want 0", dmem_req);
        end
        next_cycle();
        tests++;
        if (wbk_data_wb !== 32'h13579BDF || wbk_rd_reg_wb !== 1'b1 || rd_adr_wb !== 5'd12) begin
            fails++;
            $display("FAIL once_wb: data=%h en=%b rd=%0d want 13579bdf 1 12", wbk_data_wb, wbk_rd_reg_wb, rd_adr_wb);
        end
        clr_op();
    endtask

    task automatic test_rst_pipe;
        set_op(1'b1, 1'b0, 32'h200, 32'd0, C_W, 1'b1, 5'd3);
        dmem_ack = 1'b0; dmem_rdata = 32'h2468ACE0;
        next_cycle();
        rst_pipe = 1'b1; dmem_ack = 1'b1;
        #1;
        tests++;
        if (dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL flush_req: req=%b want 0", dmem_req);
        end
        next_cycle();
        rst_pipe = 1'b0; clr_op();
        #1;
        tests++;
        if (dc_stall !== 1'b0 || dc_stall_fin !== 1'b0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: dc_stall=%b fin=%b req=%b want 0 0 0", dc_stall, dc_stall_fin, dmem_req);
        end
        tests++;
        if (wbk_rd_reg_wb !== 1'b0 || wbk_data_wb !== 32'd0 || rd_adr_wb !== 5'd0) begin
            fails++;
            $display("FAIL flush_wb: en=%b data=%h rd=%0d want 0 0 0", wbk_rd_reg_wb, wbk_data_wb, rd_adr_wb);
        end
        next_cycle();
        dmem_ack = 1'b0;
        tests++;
        if (wbk_data_wb !== 32'd0 || dc_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_late_ack: data=%h dc_stall=%b want 0 0", wbk_data_wb, dc_stall);
        end
    endtask

    task automatic test_timeout;
        int errs = 0;
        int err_at = -1;
        int fin_at = -1;
        set_op(1'b1, 1'b0, 32'h300, 32'd0, C_W, 1'b1, 5'd4);
        dmem_ack = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (ma_bus_err) begin
                errs++;
                err_at = c;
            end
            if (dc_stall_fin) begin
                fin_at = c;
                next_cycle();
                break;
            end
            next_cycle();
        end
        tests++;
        if (errs != 1 || err_at != 255) begin
            fails++;
            $display("FAIL tmo_err: pulses=%0d at=%0d want 1 at 255", errs, err_at);
        end
        tests++;
        if (fin_at != 256) begin
            fails++;
            $display("FAIL tmo_fin: fin_at=%0d want 256", fin_at);
        end
        tests++;
        if (wbk_rd_reg_wb !== 1'b0 || wbk_data_wb !== 32'd0 || rd_adr_wb !== 5'd4) begin
            fails++;
            $display("FAIL tmo_wb: en=%b data=%h rd=%0d want 0 0 4", wbk_rd_reg_wb, wbk_data_wb, rd_adr_wb);
        end
        #1;
        tests++;
        if (dmem_req !== 1'b0 || dc_stall !== 1'b0) begin
            fails++;
            $display("FAIL tmo_reissue: req=%b dc_stall=%b want 0 0", dmem_req, dc_stall);
        end
        next_cycle();
        tests++;
        if (wbk_rd_reg_wb !== 1'b0) begin
            fails++;
            $display("FAIL tmo_wb_hold: en=%b want 0", wbk_rd_reg_wb);
        end
        clr_op();
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_wait();
        test_back_to_back();
        test_store();
        test_misalign();
        test_stall_once();
        test_rst_pipe();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
